// File: rtl/clk_div_monitor_if.sv
// Signal bundle between a clk_div_monitor and the fast-domain logic using it.
// master: drives clk_div/clear, reads strobes, period, lock/loss and high time.
interface clk_div_monitor_if #(
    parameter int CNT_W = 16
);
    logic             clk_div;
    logic             clear;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             lost;
    logic [CNT_W-1:0] high_time;

    modport master (
        output clk_div, clear,
        input  rise_pulse, fall_pulse, period, period_valid,
        input  locked, lost, high_time
    );

    modport slave (
        input  clk_div, clear,
        output rise_pulse, fall_pulse, period, period_valid,
        output locked, lost, high_time
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Fast-domain monitor for a divided clock: sync, edge strobes, period, lock/loss.
// Ports: clk_hf, rst_n (async low), mon (slave). Duty counter: CLK_MON_DUTY_EN.
module clk_div_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EXP_PERIOD  = 8,
    parameter int TOL         = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk_hf,
    input  logic             rst_n,
    clk_div_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        ACQUIRE,
        MEASURE,
        LOCKED,
        LOST
    } state_t;

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_PERIOD);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic                   cur, rise, fall;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MW-1:0]    match_q, match_d, match_inc;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;
    logic             rise_pulse_q, rise_pulse_d;
    logic             fall_pulse_q, fall_pulse_d;

    logic [CNT_W-1:0]  meas;
    logic signed [CNT_W:0] diff, adiff;
    logic              in_tol;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], mon.clk_div};
    assign cur    = sync_q[SYNC_STAGES-1];
    assign rise   = cur & ~prev_q;
    assign fall   = ~cur & prev_q;

    // cnt holds cycles since the last rise, so the period is one more.
    assign meas   = cnt_q + 1'b1;
    assign diff   = $signed({1'b0, meas}) - EXP_S;
    assign adiff  = diff[CNT_W] ? -diff : diff;
    assign in_tol = (adiff <= TOL_S);

    assign match_inc = (match_q == LOCK_N) ? match_q : match_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        period_d     = period_q;
        pv_d         = 1'b0;
        rise_pulse_d = rise;
        fall_pulse_d = fall;
        cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (rise) begin
            cnt_d = '0;
        end

        if (mon.clear) begin
            state_d = ACQUIRE;
            match_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ACQUIRE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise) begin
                        period_d = meas;
                        pv_d     = 1'b1;
                        if (in_tol) begin
                            match_d = match_inc;
                            if (match_inc == LOCK_N) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            match_d = '0;
                            state_d = MEASURE;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_d = LOST;
                    end
                end
                LOST: begin
                    if (rise) begin
                        state_d = MEASURE;
                        match_d = '0;
                    end
                end
                default: state_d = ACQUIRE;
            endcase
        end

        locked_d = (state_d == LOCKED);
        lost_d   = (state_d == LOST);
    end

    always_ff @(posedge clk_hf or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            prev_q       <= 1'b0;
            state_q      <= ACQUIRE;
            cnt_q        <= '0;
            match_q      <= '0;
            period_q     <= '0;
            pv_q         <= 1'b0;
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= cur;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            match_q      <= match_d;
            period_q     <= period_d;
            pv_q         <= pv_d;
            locked_q     <= locked_d;
            lost_q       <= lost_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
        end
    end

    assign mon.rise_pulse   = rise_pulse_q;
    assign mon.fall_pulse   = fall_pulse_q;
    assign mon.period       = period_q;
    assign mon.period_valid = pv_q;
    assign mon.locked       = locked_q;
    assign mon.lost         = lost_q;

`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;

    always_comb begin
        hcnt_d = hcnt_q;
        high_d = high_q;
        if (cur && hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + 1'b1;
        end
        if (rise) begin
            hcnt_d = '0;
        end
        if (mon.clear) begin
            high_d = '0;
        end else if (fall && (state_q == MEASURE || state_q == LOCKED)) begin
            high_d = hcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_hf or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign mon.high_time = high_q;
`else
    assign mon.high_time = '0;
`endif
endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor: two instances (TOL=0, TOL=1)
// sharing one clk_div, checked every cycle against an event-level model.
module tb_clk_div_monitor;
    localparam int CNT_W = 16;
    localparam int S     = 2;
    localparam int EXP   = 8;
    localparam int LC    = 4;
    localparam int TO    = 64;
    localparam int HN    = 16384;
    localparam int ACQ = 0, MEA = 1, LCK = 2, LST = 3;
`ifdef CLK_MON_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic clk_hf = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_hf = ~clk_hf;

    clk_div_monitor_if #(.CNT_W(CNT_W)) m0 ();
    clk_div_monitor_if #(.CNT_W(CNT_W)) m1 ();

    clk_div_monitor #(
        .CNT_W(CNT_W), .SYNC_STAGES(S), .EXP_PERIOD(EXP),
        .TOL(0), .LOCK_COUNT(LC), .TIMEOUT(TO)
    ) dut0 (.clk_hf(clk_hf), .rst_n(rst_n), .mon(m0));

    clk_div_monitor #(
        .CNT_W(CNT_W), .SYNC_STAGES(S), .EXP_PERIOD(EXP),
        .TOL(1), .LOCK_COUNT(LC), .TIMEOUT(TO)
    ) dut1 (.clk_hf(clk_hf), .rst_n(rst_n), .mon(m1));

    int tests = 0;
    int fails = 0;

    // clk_div value sampled at each clk_hf edge, indexed by edge number
    bit hist[HN];
    int cyc;

    // reference model state
    int mst[2], mmatch[2], mper[2], mhigh[2];
    bit mpv[2];
    int mlast;
    bit mrise, mfall;

    typedef struct {
        int hi;
        int lo;
        bit pv;
        int per;
        bit lk1;
        bit lk0;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s @%0d: got %0d expected %0d",
                         nm, cyc, act, exp);
        end
    endtask

    function automatic bit rise_at(input int n);
        return hist[n-S] && !hist[n-S-1];
    endfunction

    function automatic bit fall_at(input int n);
        return !hist[n-S] && hist[n-S-1];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HN; i++) hist[i] = 1'b0;
        cyc   = S + 2;
        mlast = 0;
        mrise = 1'b0;
        mfall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mst[k] = ACQ; mmatch[k] = 0; mper[k] = 0;
            mhigh[k] = 0; mpv[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit c);
        bit r, f;
        int old, meas, dev;
        r = rise_at(cyc);
        f = fall_at(cyc);
        mrise = r;
        mfall = f;
        for (int k = 0; k < 2; k++) begin
            old    = mst[k];
            mpv[k] = 1'b0;
            if (c) begin
                mst[k] = ACQ; mmatch[k] = 0; mhigh[k] = 0;
            end else begin
                if (DUTY && f && (old == MEA || old == LCK))
                    mhigh[k] = cyc - mlast;
                case (old)
                    ACQ: if (r) mst[k] = MEA;
                    MEA, LCK: begin
                        if (r) begin
                            meas = cyc - mlast;
                            mper[k] = meas;
                            mpv[k] = 1'b1;
                            dev = meas - EXP;
                            if (dev < 0) dev = -dev;
                            if (dev <= k) begin
                                if (mmatch[k] < LC) mmatch[k]++;
                                if (mmatch[k] == LC) mst[k] = LCK;
                            end else begin
                                mmatch[k] = 0;
                                mst[k] = MEA;
                            end
                        end else if (cyc - mlast >= TO) begin
                            mst[k] = LST;
                        end
                    end
                    default: if (r) begin mst[k] = MEA; mmatch[k] = 0; end
                endcase
            end
        end
        if (r) mlast = cyc;
    endtask

    task automatic chk_dut(input int k, input logic rp, input logic fp,
                           input logic [CNT_W-1:0] per, input logic pv,
                           input logic lk, input logic ls,
                           input logic [CNT_W-1:0] ht);
        chk($sformatf("d%0d rise_pulse", k), 32'(rp), 32'(mrise));
        chk($sformatf("d%0d fall_pulse", k), 32'(fp), 32'(mfall));
        chk($sformatf("d%0d period", k), 32'(per), mper[k]);
        chk($sformatf("d%0d period_valid", k), 32'(pv), 32'(mpv[k]));
        chk($sformatf("d%0d locked", k), 32'(lk), 32'(mst[k] == LCK));
        chk($sformatf("d%0d lost", k), 32'(ls), 32'(mst[k] == LST));
        chk($sformatf("d%0d high_time", k), 32'(ht), mhigh[k]);
    endtask

    task automatic check_all();
        chk_dut(0, m0.rise_pulse, m0.fall_pulse, m0.period,
                m0.period_valid, m0.locked, m0.lost, m0.high_time);
        chk_dut(1, m1.rise_pulse, m1.fall_pulse, m1.period,
                m1.period_valid, m1.locked, m1.lost, m1.high_time);
    endtask

    // called at a negedge; drives inputs for the next posedge
    task automatic tick(input bit d, input bit clr_on_rise, input bit clr);
        bit c;
        cyc++;
        hist[cyc] = d;
        c = clr | (clr_on_rise && rise_at(cyc));
        m0.clk_div = d; m1.clk_div = d;
        m0.clear   = c; m1.clear   = c;
        @(posedge clk_hf);
        model_edge(c);
        @(negedge clk_hf);
        check_all();
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        model_reset();
        m0.clear = 1'b0; m1.clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m0.clk_div = ~m0.clk_div;
            m1.clk_div = m0.clk_div;
            @(negedge clk_hf);
            check_all();
        end
        m0.clk_div = 1'b0; m1.clk_div = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic drive_period(input int hi, input int lo, input bit cor,
                                output bit seen, output int per,
                                output bit lk1, output bit lk0);
        seen = 1'b0; per = 0; lk1 = 1'b0; lk0 = 1'b0;
        for (int i = 0; i < hi + lo; i++) begin
            tick(i < hi, cor, 1'b0);
            if (m1.period_valid) begin
                seen = 1'b1;
                per  = 32'(m1.period);
                lk1  = m1.locked;
                lk0  = m0.locked;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen, lk1, lk0, found, lk_at;
        int per, rp_c, lost_c, hi, lo, mode, ct;

        tbl[0] = '{4, 4, 1'b0, 0,  1'b0, 1'b0};
        tbl[1] = '{4, 4, 1'b1, 8,  1'b0, 1'b0};
        tbl[2] = '{4, 4, 1'b1, 8,  1'b0, 1'b0};
        tbl[3] = '{4, 4, 1'b1, 8,  1'b0, 1'b0};
        tbl[4] = '{5, 4, 1'b1, 8,  1'b1, 1'b1};
        tbl[5] = '{5, 5, 1'b1, 9,  1'b1, 1'b0};
        tbl[6] = '{4, 4, 1'b1, 10, 1'b0, 1'b0};
        tbl[7] = '{4, 4, 1'b1, 8,  1'b0, 1'b0};

        m0.clk_div = 1'b0; m1.clk_div = 1'b0;
        hold_reset();

        // acquisition, lock, tolerance 9 vs 10
        for (int i = 0; i < 8; i++) begin
            drive_period(tbl[i].hi, tbl[i].lo, 1'b0, seen, per, lk1, lk0);
            chk($sformatf("tbl%0d period_valid", i), 32'(seen), 32'(tbl[i].pv));
            if (tbl[i].pv) begin
                chk($sformatf("tbl%0d period", i), per, tbl[i].per);
                chk($sformatf("tbl%0d locked tol1", i), 32'(lk1), 32'(tbl[i].lk1));
                chk($sformatf("tbl%0d locked tol0", i), 32'(lk0), 32'(tbl[i].lk0));
            end
        end

        // relock, then stop clk_div low
        for (int i = 0; i < 4; i++) drive_period(4, 4, 1'b0, seen, per, lk1, lk0);
        chk("relocked", 32'(m1.locked), 1);
        rp_c = 0; lost_c = 0; found = 1'b0; lk_at = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(i < 4, 1'b0, 1'b0);
            if (m1.rise_pulse) rp_c = cyc;
            if (m1.lost) begin
                found = 1'b1; lost_c = cyc; lk_at = m1.locked;
            end
        end
        chk("lost seen", 32'(found), 1);
        chk("lost delay", lost_c - rp_c, TO);
        chk("locked at lost", 32'(lk_at), 0);

        // restart: no period on first rise, lock 4 periods later
        for (int i = 0; i < 5; i++) begin
            drive_period(4, 4, 1'b0, seen, per, lk1, lk0);
            chk($sformatf("restart%0d period_valid", i), 32'(seen), 32'(i > 0));
            chk($sformatf("restart%0d locked", i), 32'(m1.locked), 32'(i == 4));
        end

        // clear on the rise edge while locked
        drive_period(4, 4, 1'b1, seen, per, lk1, lk0);
        chk("clear period_valid", 32'(seen), 0);
        chk("clear locked", 32'(m1.locked), 0);
        chk("clear lost", 32'(m1.lost), 0);
        chk("clear period kept", 32'(m1.period), 8);
        drive_period(4, 4, 1'b0, seen, per, lk1, lk0);
        chk("after clear first rise", 32'(seen), 0);
        drive_period(4, 4, 1'b0, seen, per, lk1, lk0);
        chk("after clear second rise", 32'(seen), 1);

        // duty: 3 high / 5 low
        for (int i = 0; i < 4; i++) begin
            drive_period(3, 5, 1'b0, seen, per, lk1, lk0);
            chk($sformatf("duty%0d high_time", i), 32'(m1.high_time),
                DUTY ? 3 : 0);
            chk($sformatf("duty%0d period", i), 32'(m1.period), 8);
        end

        // randomized bursts against the model
        for (int b = 0; b < 40; b++) begin
            mode = $urandom_range(0, 9);
            for (int p = 0; p < 6; p++) begin
                if (mode < 6) begin
                    hi = $urandom_range(3, 5);
                    lo = $urandom_range(7, 9) - hi;
                end else if (mode < 8) begin
                    hi = $urandom_range(1, 6);
                    lo = $urandom_range(1, 8);
                end else begin
                    hi = $urandom_range(1, 5);
                    lo = $urandom_range(60, 75);
                end
                ct = ($urandom_range(0, 30) == 0) ? $urandom_range(0, hi + lo - 1) : -1;
                for (int i = 0; i < hi + lo; i++) tick(i < hi, 1'b0, i == ct);
            end
        end

        // asynchronous reset in mid-operation
        for (int i = 0; i < 5; i++) drive_period(4, 4, 1'b0, seen, per, lk1, lk0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset locked", 32'(m1.locked), 0);
        chk("async reset period", 32'(m1.period), 0);
        chk("async reset rise_pulse", 32'(m1.rise_pulse), 0);
        @(negedge clk_hf);
        hold_reset();
        for (int i = 0; i < 6; i++) drive_period(4, 4, 1'b0, seen, per, lk1, lk0);
        chk("post reset locked", 32'(m1.locked), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
